// File: rtl/legv8_pkg.sv
// Shared types and opcode constants for the LEGv8 decode stage.
package legv8_pkg;

    localparam int WORD      = 64;
    localparam int INST_SIZE = 32;
    localparam int NREG      = 32;

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    // I-type opcodes are 10 bits; bit 21 belongs to the immediate.
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;
    localparam logic [5:0]  OP_B    = 6'h05;

    typedef enum logic [1:0] {
        ALU_LDST  = 2'b00,
        ALU_CB    = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_B     = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic alu_src;
        logic sreg_up;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic uncond_br;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    typedef struct packed {
        logic                 valid;
        alu_op_e              alu_op;
        ctrl_t                ctrl;
        logic [4:0]           rd;
        logic [WORD-1:0]      data1;
        logic [WORD-1:0]      data2;
        logic [WORD-1:0]      ext;
        logic [INST_SIZE-1:0] inst;
        logic [WORD-1:0]      pc;
    } idex_t;

endpackage

// File: rtl/id_stage_if.sv
// IF/ID inputs, writeback port, hazard output and ID/EX outputs of the decode stage.
interface id_stage_if;
    import legv8_pkg::*;

    logic                 if_valid;
    logic [INST_SIZE-1:0] inst;
    logic [WORD-1:0]      pc;
    logic                 stall;
    logic                 flush;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [WORD-1:0]      wb_data;

    logic                 hz_stall;
    logic                 ex_valid;
    logic [WORD-1:0]      ex_r_data1;
    logic [WORD-1:0]      ex_r_data2;
    logic [WORD-1:0]      ex_ex_data;
    logic [INST_SIZE-1:0] ex_inst;
    logic [WORD-1:0]      ex_pc;
    logic [1:0]           ex_ALUOp;
    logic                 ex_ALUSrc;
    logic                 ex_SregUp;
    logic                 ex_MemRead;
    logic                 ex_MemWrite;
    logic                 ex_RegWrite;
    logic                 ex_MemtoReg;
    logic                 ex_Branch;
    logic                 ex_UncondBr;
    logic [4:0]           ex_rd;

    modport master (
        output if_valid, inst, pc, stall, flush, wb_en, wb_addr, wb_data,
        input  hz_stall, ex_valid, ex_r_data1, ex_r_data2, ex_ex_data, ex_inst, ex_pc,
               ex_ALUOp, ex_ALUSrc, ex_SregUp, ex_MemRead, ex_MemWrite, ex_RegWrite,
               ex_MemtoReg, ex_Branch, ex_UncondBr, ex_rd
    );

    modport slave (
        input  if_valid, inst, pc, stall, flush, wb_en, wb_addr, wb_data,
        output hz_stall, ex_valid, ex_r_data1, ex_r_data2, ex_ex_data, ex_inst, ex_pc,
               ex_ALUOp, ex_ALUSrc, ex_SregUp, ex_MemRead, ex_MemWrite, ex_RegWrite,
               ex_MemtoReg, ex_Branch, ex_UncondBr, ex_rd
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// 32x64 register file: two read ports, one write port, X31 reads zero, write-through bypass.
module id_stage_reg_file
    import legv8_pkg::*;
(
    input  logic            clk,
    input  logic            i_wr_en,
    input  logic [4:0]      i_wr_addr,
    input  logic [WORD-1:0] i_wr_data,
    input  logic [4:0]      i_rd_addr1,
    input  logic [4:0]      i_rd_addr2,
    output logic [WORD-1:0] o_rd_data1,
    output logic [WORD-1:0] o_rd_data2
);

    logic [WORD-1:0] r_regs [NREG];
    logic            w_wr_ok;

    assign w_wr_ok = i_wr_en && (i_wr_addr != XZR);

    // Contents are deliberately not reset; only the pipeline register is.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_regs[i_wr_addr] <= i_wr_data;
    end

    always_comb begin
        o_rd_data1 = r_regs[i_rd_addr1];
        if (i_rd_addr1 == XZR)                        o_rd_data1 = '0;
        else if (w_wr_ok && i_wr_addr == i_rd_addr1) o_rd_data1 = i_wr_data;
    end

    always_comb begin
        o_rd_data2 = r_regs[i_rd_addr2];
        if (i_rd_addr2 == XZR)                        o_rd_data2 = '0;
        else if (w_wr_ok && i_wr_addr == i_rd_addr2) o_rd_data2 = i_wr_data;
    end

endmodule

// File: rtl/id_stage.sv
// LEGv8 decode stage: decoder, immediate extender, load-use hazard detect and ID/EX register.
module id_stage
    import legv8_pkg::*;
(
    input logic     clk,
    input logic     rst_n,
    id_stage_if.slave bus
);

    alu_op_e         w_alu_op;
    ctrl_t           w_ctrl;
    logic [WORD-1:0] w_ext;
    logic [4:0]      w_reg1;
    logic [4:0]      w_reg2;
    logic            w_reg2_used;
    logic [WORD-1:0] w_rd_data1;
    logic [WORD-1:0] w_rd_data2;
    logic            w_hz;
    idex_t           w_next;
    idex_t           r_idex;

    assign w_reg1 = bus.inst[9:5];

    always_comb begin
        w_alu_op    = ALU_LDST;
        w_ctrl      = CTRL_NONE;
        w_ext       = '0;
        w_reg2      = bus.inst[20:16];
        w_reg2_used = 1'b0;
        if (bus.inst[31:26] == OP_B) begin
            w_alu_op         = ALU_B;
            w_ctrl.uncond_br = 1'b1;
            w_ext            = {{(WORD-26){bus.inst[25]}}, bus.inst[25:0]};
        end else if (bus.inst[31:24] == OP_CBZ || bus.inst[31:24] == OP_CBNZ) begin
            w_alu_op       = ALU_CB;
            w_ctrl.alu_src = 1'b1;
            w_ctrl.sreg_up = 1'b1;
            w_ctrl.branch  = 1'b1;
            w_reg2         = bus.inst[4:0];
            w_reg2_used    = 1'b1;
            w_ext          = {{(WORD-19){bus.inst[23]}}, bus.inst[23:5]};
        end else if (bus.inst[31:22] == OP_ADDI || bus.inst[31:22] == OP_SUBI) begin
            w_alu_op         = ALU_RTYPE;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_ext            = {{(WORD-12){1'b0}}, bus.inst[21:10]};
        end else begin
            case (bus.inst[31:21])
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    w_alu_op         = ALU_RTYPE;
                    w_ctrl.reg_write = 1'b1;
                    w_reg2_used      = 1'b1;
                end
                OP_LDUR: begin
                    w_ctrl.alu_src    = 1'b1;
                    w_ctrl.mem_read   = 1'b1;
                    w_ctrl.mem_to_reg = 1'b1;
                    w_ctrl.reg_write  = 1'b1;
                    w_ext             = {{(WORD-9){bus.inst[20]}}, bus.inst[20:12]};
                end
                OP_STUR: begin
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.mem_write = 1'b1;
                    w_reg2           = bus.inst[4:0];
                    w_reg2_used      = 1'b1;
                    w_ext            = {{(WORD-9){bus.inst[20]}}, bus.inst[20:12]};
                end
                default: ;
            endcase
        end
    end

    id_stage_reg_file u_reg_file (
        .clk        (clk),
        .i_wr_en    (bus.wb_en),
        .i_wr_addr  (bus.wb_addr),
        .i_wr_data  (bus.wb_data),
        .i_rd_addr1 (w_reg1),
        .i_rd_addr2 (w_reg2),
        .o_rd_data1 (w_rd_data1),
        .o_rd_data2 (w_rd_data2)
    );

    // A load in EX whose destination feeds this instruction must not issue yet.
    assign w_hz = bus.if_valid && r_idex.valid && r_idex.ctrl.mem_read && (r_idex.rd != XZR) &&
                  ((r_idex.rd == w_reg1) || ((r_idex.rd == w_reg2) && w_reg2_used));

    always_comb begin
        w_next        = '0;
        w_next.valid  = bus.if_valid;
        w_next.alu_op = bus.if_valid ? w_alu_op : ALU_LDST;
        w_next.ctrl   = bus.if_valid ? w_ctrl : CTRL_NONE;
        w_next.rd     = bus.inst[4:0];
        w_next.data1  = w_rd_data1;
        w_next.data2  = w_rd_data2;
        w_next.ext    = w_ext;
        w_next.inst   = bus.inst;
        w_next.pc     = bus.pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_idex <= '0;
        else if (bus.flush || (w_hz && !bus.stall)) r_idex <= '0;
        else if (!bus.stall)                     r_idex <= w_next;
    end

    assign bus.hz_stall    = w_hz;
    assign bus.ex_valid    = r_idex.valid;
    assign bus.ex_r_data1  = r_idex.data1;
    assign bus.ex_r_data2  = r_idex.data2;
    assign bus.ex_ex_data  = r_idex.ext;
    assign bus.ex_inst     = r_idex.inst;
    assign bus.ex_pc       = r_idex.pc;
    assign bus.ex_ALUOp    = r_idex.alu_op;
    assign bus.ex_ALUSrc   = r_idex.ctrl.alu_src;
    assign bus.ex_SregUp   = r_idex.ctrl.sreg_up;
    assign bus.ex_MemRead  = r_idex.ctrl.mem_read;
    assign bus.ex_MemWrite = r_idex.ctrl.mem_write;
    assign bus.ex_RegWrite = r_idex.ctrl.reg_write;
    assign bus.ex_MemtoReg = r_idex.ctrl.mem_to_reg;
    assign bus.ex_Branch   = r_idex.ctrl.branch;
    assign bus.ex_UncondBr = r_idex.ctrl.uncond_br;
    assign bus.ex_rd       = r_idex.rd;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic against a decode-table model.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_stage_if bus();
    id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model of architectural state and of the ID/EX entry.
    logic [63:0] m_rf [32];
    logic        m_valid;
    logic [1:0]  m_aluop;
    logic [7:0]  m_ctrl;   // ALUSrc SregUp MemRead MemWrite RegWrite MemtoReg Branch UncondBr
    logic [4:0]  m_rd;
    logic [63:0] m_d1, m_d2, m_ext, m_pc;
    logic [31:0] m_inst;
    logic        m_d2_care, m_ext_care;

    typedef struct {
        logic [1:0]  aluop;
        logic [7:0]  ctrl;
        logic [63:0] ext;
        logic [4:0]  reg2;
        logic        r2used;
        logic        extcare;
    } dec_t;

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        if (v[bits-1]) return v - (64'd1 << bits);
        return v;
    endfunction

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        logic [10:0] op11;
        op11 = i[31:21];
        d.aluop = 2'b00; d.ctrl = 8'h00; d.ext = 64'd0;
        d.reg2 = i[20:16]; d.r2used = 1'b0; d.extcare = 1'b0;
        if (op11 inside {11'h458, 11'h658, 11'h450, 11'h550}) begin
            d.aluop = 2'b10; d.ctrl = 8'b0000_1000; d.r2used = 1'b1;
        end else if (op11 inside {11'h488, 11'h489, 11'h688, 11'h689}) begin
            d.aluop = 2'b10; d.ctrl = 8'b1000_1000; d.ext = 64'(i[21:10]); d.extcare = 1'b1;
        end else if (op11 == 11'h7C2) begin
            d.ctrl = 8'b1010_1100; d.ext = sext(64'(i[20:12]), 9); d.extcare = 1'b1;
        end else if (op11 == 11'h7C0) begin
            d.ctrl = 8'b1001_0000; d.ext = sext(64'(i[20:12]), 9); d.extcare = 1'b1;
            d.reg2 = i[4:0]; d.r2used = 1'b1;
        end else if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5) begin
            d.aluop = 2'b01; d.ctrl = 8'b1100_0010; d.ext = sext(64'(i[23:5]), 19); d.extcare = 1'b1;
            d.reg2 = i[4:0]; d.r2used = 1'b1;
        end else if (i[31:26] == 6'h05) begin
            d.aluop = 2'b11; d.ctrl = 8'b0000_0001; d.ext = sext(64'(i[25:0]), 26); d.extcare = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [63:0] mread(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    function automatic logic m_hz();
        dec_t d;
        d = decode(bus.inst);
        return bus.if_valid && m_valid && m_ctrl[5] && (m_rd != 5'd31) &&
               ((m_rd == bus.inst[9:5]) || ((m_rd == d.reg2) && d.r2used));
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {bus.ex_ALUSrc, bus.ex_SregUp, bus.ex_MemRead, bus.ex_MemWrite,
                bus.ex_RegWrite, bus.ex_MemtoReg, bus.ex_Branch, bus.ex_UncondBr};
    endfunction

    function automatic logic [303:0] raw_vec();
        return {bus.ex_valid, bus.ex_ALUOp, dut_ctrl(), bus.ex_rd, bus.ex_r_data1,
                bus.ex_r_data2, bus.ex_ex_data, bus.ex_inst, bus.ex_pc};
    endfunction

    // Data fields only matter for a valid entry, and Rm/imm only where the format defines them.
    function automatic logic [303:0] dut_vec();
        return {bus.ex_valid, bus.ex_ALUOp, dut_ctrl(),
                m_valid ? bus.ex_rd : 5'd0,
                m_valid ? bus.ex_r_data1 : 64'd0,
                (m_valid && m_d2_care) ? bus.ex_r_data2 : 64'd0,
                (m_valid && m_ext_care) ? bus.ex_ex_data : 64'd0,
                m_valid ? bus.ex_inst : 32'd0,
                m_valid ? bus.ex_pc : 64'd0};
    endfunction

    function automatic logic [303:0] exp_vec();
        return {m_valid, m_aluop, m_ctrl,
                m_valid ? m_rd : 5'd0,
                m_valid ? m_d1 : 64'd0,
                (m_valid && m_d2_care) ? m_d2 : 64'd0,
                (m_valid && m_ext_care) ? m_ext : 64'd0,
                m_valid ? m_inst : 32'd0,
                m_valid ? m_pc : 64'd0};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_aluop = 0; m_ctrl = 0; m_rd = 0; m_d1 = 0; m_d2 = 0;
        m_ext = 0; m_inst = 0; m_pc = 0; m_d2_care = 0; m_ext_care = 0;
    endtask

    task automatic set_in(input logic v, input logic [31:0] i, input logic [63:0] p,
                          input logic st, input logic fl, input logic we,
                          input logic [4:0] wa, input logic [63:0] wd);
        bus.if_valid = v; bus.inst = i; bus.pc = p; bus.stall = st; bus.flush = fl;
        bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    endtask

    // Advance one clock and move the model with it.
    task automatic tick();
        logic hz, st, fl, we, v;
        logic [4:0] wa;
        logic [63:0] wd, d1, d2, p;
        logic [31:0] i;
        dec_t d;
        hz = m_hz(); st = bus.stall; fl = bus.flush; v = bus.if_valid;
        we = bus.wb_en; wa = bus.wb_addr; wd = bus.wb_data; i = bus.inst; p = bus.pc;
        d = decode(i);
        d1 = mread(i[9:5]); d2 = mread(d.reg2);
        @(posedge clk);
        if (fl || (hz && !st)) model_clear();
        else if (!st) begin
            m_valid = v; m_aluop = v ? d.aluop : 2'b00; m_ctrl = v ? d.ctrl : 8'h00;
            m_rd = i[4:0]; m_d1 = d1; m_d2 = d2; m_ext = d.ext; m_inst = i; m_pc = p;
            m_d2_care = d.r2used; m_ext_care = d.extcare;
        end
        if (we && wa != 5'd31) m_rf[wa] = wd;
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 7) == 0) return 5'd31;
        return 5'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rn, rm, rd;
        logic [10:0] rops [4];
        rops = '{11'h458, 11'h658, 11'h450, 11'h550};
        rn = pick_reg(); rm = pick_reg(); rd = pick_reg();
        case ($urandom_range(0, 7))
            0: return {rops[$urandom_range(0, 3)], rm, 6'($urandom), rn, rd};
            1: return {($urandom_range(0, 1) ? 10'h244 : 10'h344), 12'($urandom), rn, rd};
            2, 7: return {11'h7C2, 9'($urandom), 2'b00, rn, rd};
            3: return {11'h7C0, 9'($urandom), 2'b00, rn, rd};
            4: return {($urandom_range(0, 1) ? 8'hB4 : 8'hB5), 19'($urandom), rd};
            5: return {6'h05, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        set_in(0, 32'd0, 64'd0, 0, 0, 0, 5'd0, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        total++;
        if (raw_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", raw_vec());
        end
        total++;
        if (bus.hz_stall !== 1'b0) begin
            bad++; $display("FAIL reset_hz got=%b want=0", bus.hz_stall);
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        // Preload every register; X22 gets the value the directed load test relies on.
        for (int a = 0; a < 31; a++) begin
            set_in(0, 32'd0, 64'd0, 0, 0, 1, 5'(a), (a == 22) ? 64'd22 : {$urandom, $urandom});
            tick();
        end
        set_in(0, 32'd0, 64'd0, 0, 1, 0, 5'd0, 64'd0);
        tick();
    endtask

    task automatic test_load_use();
        set_in(1, 32'hF84402C9, 64'd100, 0, 0, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if ({bus.ex_valid, bus.ex_r_data1, bus.ex_ex_data, bus.ex_ALUOp, bus.ex_ALUSrc, bus.ex_MemRead, bus.ex_rd}
            !== {1'b1, 64'd22, 64'd64, 2'b00, 1'b1, 1'b1, 5'd9}) begin
            bad++; $display("FAIL ldur_fields got=%h/%h/%h/%b/%b/%b/%0d", bus.ex_valid, bus.ex_r_data1,
                            bus.ex_ex_data, bus.ex_ALUOp, bus.ex_ALUSrc, bus.ex_MemRead, bus.ex_rd);
        end
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL ldur_model got=%h want=%h", dut_vec(), exp_vec());
        end
        // ADD X10,X19,X9 while the load is in EX, first with a downstream stall on top.
        set_in(1, 32'h8B09026A, 64'd104, 1, 0, 0, 5'd0, 64'd0);
        #1;
        total++;
        if (bus.hz_stall !== 1'b1) begin
            bad++; $display("FAIL hz_detect got=%b want=1", bus.hz_stall);
        end
        tick();
        total++;
        if (bus.ex_MemRead !== 1'b1 || bus.ex_rd !== 5'd9 || bus.hz_stall !== 1'b1) begin
            bad++; $display("FAIL stall_over_hz got=%b/%0d/%b want=1/9/1", bus.ex_MemRead, bus.ex_rd, bus.hz_stall);
        end
        bus.stall = 1'b0;
        #1 tick();
        total++;
        if (bus.ex_valid !== 1'b0 || dut_ctrl() !== 8'h00) begin
            bad++; $display("FAIL hz_bubble got=%b/%h want=0/00", bus.ex_valid, dut_ctrl());
        end
        tick();
        total++;
        if ({bus.ex_valid, bus.ex_ALUOp, bus.ex_RegWrite, bus.ex_inst[20:16], bus.ex_rd} !== {1'b1, 2'b10, 1'b1, 5'd9, 5'd10}) begin
            bad++; $display("FAIL add_issue got=%b/%b/%b/%0d/%0d", bus.ex_valid, bus.ex_ALUOp, bus.ex_RegWrite,
                            bus.ex_inst[20:16], bus.ex_rd);
        end
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL add_model got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_branches();
        logic [303:0] held;
        set_in(1, 32'hB4FFFF6B, 64'd200, 0, 0, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if ({bus.ex_ex_data, bus.ex_ALUOp, bus.ex_SregUp, bus.ex_Branch, bus.ex_pc}
            !== {64'hFFFF_FFFF_FFFF_FFFB, 2'b01, 1'b1, 1'b1, 64'd200}) begin
            bad++; $display("FAIL cbz got=%h/%b/%b/%b/%0d", bus.ex_ex_data, bus.ex_ALUOp, bus.ex_SregUp,
                            bus.ex_Branch, bus.ex_pc);
        end
        set_in(1, 32'h14000040, 64'd204, 0, 0, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if ({bus.ex_ex_data, bus.ex_ALUOp, bus.ex_UncondBr, bus.ex_Branch} !== {64'd64, 2'b11, 1'b1, 1'b0}) begin
            bad++; $display("FAIL b_uncond got=%h/%b/%b/%b", bus.ex_ex_data, bus.ex_ALUOp, bus.ex_UncondBr, bus.ex_Branch);
        end
        held = raw_vec();
        set_in(1, 32'h8B09026A, 64'd208, 1, 0, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if (raw_vec() !== held) begin
            bad++; $display("FAIL stall_hold got=%h want=%h", raw_vec(), held);
        end
        set_in(1, 32'h8B09026A, 64'd208, 0, 1, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if (raw_vec() !== '0) begin
            bad++; $display("FAIL flush_bubble got=%h want=0", raw_vec());
        end
    endtask

    task automatic test_bypass();
        // ADD X1,X5,X2 while WB writes X5 in the same cycle.
        set_in(1, {11'h458, 5'd2, 6'd0, 5'd5, 5'd1}, 64'd300, 0, 0, 1, 5'd5, 64'hABCD);
        #1 tick();
        total++;
        if (bus.ex_r_data1 !== 64'hABCD) begin
            bad++; $display("FAIL bypass got=%h want=abcd", bus.ex_r_data1);
        end
        set_in(1, {11'h458, 5'd31, 6'd0, 5'd31, 5'd1}, 64'd304, 0, 0, 1, 5'd31, 64'hFFFF_0000_1234_5678);
        #1 tick();
        total++;
        if (bus.ex_r_data1 !== 64'd0 || bus.ex_r_data2 !== 64'd0) begin
            bad++; $display("FAIL xzr_bypass got=%h/%h want=0/0", bus.ex_r_data1, bus.ex_r_data2);
        end
        set_in(1, {11'h458, 5'd31, 6'd0, 5'd5, 5'd1}, 64'd308, 0, 0, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if (bus.ex_r_data1 !== 64'hABCD || bus.ex_r_data2 !== 64'd0) begin
            bad++; $display("FAIL stored_x5 got=%h/%h want=abcd/0", bus.ex_r_data1, bus.ex_r_data2);
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, 32'hF84402C9, 64'd400, 0, 0, 0, 5'd0, 64'd0);
        #1 tick();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        total++;
        if (raw_vec() !== '0) begin
            bad++; $display("FAIL reset_mid got=%h want=0", raw_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 32'hF84402C9, 64'd404, 0, 0, 0, 5'd0, 64'd0);
        #1 tick();
        total++;
        if (bus.ex_r_data1 !== 64'd22 || bus.ex_valid !== 1'b1) begin
            bad++; $display("FAIL rf_survives_reset got=%h/%b want=16/1", bus.ex_r_data1, bus.ex_valid);
        end
    endtask

    task automatic test_random();
        logic exp_hz;
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 9) != 0), rand_inst(), {$urandom, $urandom},
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                   1'($urandom_range(0, 1)), pick_reg(), {$urandom, $urandom});
            #1;
            exp_hz = m_hz();
            total++;
            if (bus.hz_stall !== exp_hz) begin
                bad++; $display("FAIL rand_hz n=%0d inst=%h got=%b want=%b", n, bus.inst, bus.hz_stall, exp_hz);
            end
            tick();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL rand_idex n=%0d got=%h want=%h", n, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branches();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
